// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, instr} pairs with flush.
// Optional empty-queue pass-through is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [PC_W-1:0]          push_pc,
  input  logic [INSTR_W-1:0]       push_instr,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [PC_W-1:0]          pop_pc,
  output logic [INSTR_W-1:0]       pop_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL = CNT_W'(DEPTH);
  localparam logic [INSTR_W-1:0] NOP  = INSTR_W'(32'h0000_0013);

  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               stored_valid;
  logic               bypass;
  logic               push_fire;
  logic               pop_fire;
  logic               wr_en;
  logic               rd_en;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; ready never depends on the partner's valid, and push_ready is derived
  // from registered occupancy only, so a pop cannot free a slot for the same cycle.
  assign push_ready   = (count != FULL);
  assign stored_valid = (count != '0);

`ifdef FETCHQ_BYPASS_EN
  assign bypass = !stored_valid && push_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    pop_valid = stored_valid | bypass;
    pop_pc    = '0;
    pop_instr = NOP;
    if (bypass) begin
      pop_pc    = push_pc;
      pop_instr = push_instr;
    end else if (stored_valid) begin
      pop_pc    = mem_pc[rd_ptr];
      pop_instr = mem_instr[rd_ptr];
    end
  end

  assign push_fire = push_valid & push_ready;
  assign pop_fire  = pop_valid & pop_ready;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign wr_en     = push_fire & ~flush & ~(bypass & pop_ready);
  assign rd_en     = pop_fire & stored_valid & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr]    <= push_pc;
      mem_instr[wr_ptr] <= push_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: table-driven fill/drain plus hand-written corner sequences,
// with a {pc, instr} scoreboard queue checked whenever decode consumes an entry.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_pc;
  logic [31:0] pop_instr;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_pc(push_pc), .push_instr(push_instr),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_pc(pop_pc), .pop_instr(pop_instr),
    .count(count)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        flush;
    logic        pv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pr;
    int          cnt;
    logic        prdy;
    logic        pvld;
  } vec_t;

  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  vec_t        fill_tbl[11];

  function automatic vec_t mk(logic f, logic pv, logic [31:0] pc, logic [31:0] instr,
                              logic pr, int cnt, logic prdy, logic pvld);
    vec_t v;
    v.flush = f; v.pv = pv; v.pc = pc; v.instr = instr; v.pr = pr;
    v.cnt = cnt; v.prdy = prdy; v.pvld = pvld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: called just after a rising edge; checks outputs mid-cycle, then
  // advances the scoreboard to match what the clock edge will transfer.
  task automatic apply(input vec_t v);
    logic [63:0] head;
    flush      = v.flush;
    push_valid = v.pv;
    push_pc    = v.pc;
    push_instr = v.instr;
    pop_ready  = v.pr;
    #4;
    chk("count", 64'(count), 64'(v.cnt));
    chk("push_ready", 64'(push_ready), 64'(v.prdy));
    chk("pop_valid", 64'(pop_valid), 64'(v.pvld));
    if (!v.pvld) begin
      chk("empty_pop_pc", 64'(pop_pc), 64'h0);
      chk("empty_pop_instr", 64'(pop_instr), 64'(NOP));
    end
    if (v.flush) begin
      exp_q.delete();
    end else begin
      if (v.pv && v.prdy) exp_q.push_back({v.pc, v.instr});
      if (v.pvld && v.pr) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 64'(pop_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          head = exp_q.pop_front();
          chk("pop_data", {pop_pc, pop_instr}, head);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cnt, input logic pvld);
    apply(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, cnt, (cnt != DEPTH), pvld));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_pc = '0; push_instr = '0;

    fill_tbl[0]  = mk(0, 1, 32'h100, 32'h0050_0093, 0, 0, 1, BYP);
    fill_tbl[1]  = mk(0, 1, 32'h104, 32'h0010_0113, 0, 1, 1, 1);
    fill_tbl[2]  = mk(0, 1, 32'h108, 32'h0020_81B3, 0, 2, 1, 1);
    fill_tbl[3]  = mk(0, 1, 32'h10C, 32'h4020_8233, 0, 3, 1, 1);
    fill_tbl[4]  = mk(0, 1, 32'h110, 32'hDEAD_BEEF, 0, 4, 0, 1);
    fill_tbl[5]  = mk(0, 1, 32'h110, 32'hDEAD_BEEF, 0, 4, 0, 1);
    fill_tbl[6]  = mk(0, 0, 32'h0,   32'h0,         1, 4, 0, 1);
    fill_tbl[7]  = mk(0, 0, 32'h0,   32'h0,         1, 3, 1, 1);
    fill_tbl[8]  = mk(0, 0, 32'h0,   32'h0,         1, 2, 1, 1);
    fill_tbl[9]  = mk(0, 0, 32'h0,   32'h0,         1, 1, 1, 1);
    fill_tbl[10] = mk(0, 0, 32'h0,   32'h0,         0, 0, 1, 0);

    // reset state
    #3;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_pop_valid", 64'(pop_valid), 64'h0);
    chk("rst_push_ready", 64'(push_ready), 64'h1);
    chk("rst_pop_pc", 64'(pop_pc), 64'h0);
    chk("rst_pop_instr", 64'(pop_instr), 64'(NOP));
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // fill with stalled consumer, fifth push held, then drain in order
    foreach (fill_tbl[i]) apply(fill_tbl[i]);

    // simultaneous push and pop at count=2, pointers wrap several times
    apply(mk(0, 1, 32'h400, 32'h1000_0000, 0, 0, 1, BYP));
    apply(mk(0, 1, 32'h404, 32'h1000_0001, 0, 1, 1, 1));
    for (int k = 0; k < 10; k++) begin
      apply(mk(0, 1, 32'h408 + 32'(4 * k), 32'h1000_0002 + 32'(k), 1, 2, 1, 1));
    end
    apply(mk(0, 0, 32'h0, 32'h0, 1, 2, 1, 1));
    apply(mk(0, 0, 32'h0, 32'h0, 1, 1, 1, 1));
    idle(0, 1'b0);

    // full plus pop: pop accepted, push refused
    for (int k = 0; k < DEPTH; k++) begin
      apply(mk(0, 1, 32'h500 + 32'(4 * k), $urandom_range(0, 32'hFFFF), 0, k, 1,
               (k != 0) || BYP));
    end
    apply(mk(0, 1, 32'h510, 32'h5555_AAAA, 1, 4, 0, 1));
    idle(3, 1'b1);

    // flush at count=3 with a push of 0x200 and a pop request
    apply(mk(1, 1, 32'h200, 32'h0000_0200, 1, 3, 1, 1));
    apply(mk(0, 0, 32'h0, 32'h0, 1, 0, 1, 0));
    apply(mk(0, 1, 32'h600, 32'h0000_0600, 0, 0, 1, BYP));
    apply(mk(0, 0, 32'h0, 32'h0, 1, 1, 1, 1));
    idle(0, 1'b0);

    // empty-queue latency: zero with bypass, one cycle without
    apply(mk(0, 1, 32'h300, 32'h0000_0063, 1, 0, 1, BYP));
    apply(mk(0, 0, 32'h0, 32'h0, 1, BYP ? 0 : 1, 1, !BYP));
    idle(0, 1'b0);

    // asynchronous reset mid-cycle with two entries held
    apply(mk(0, 1, 32'h700, 32'h0000_0700, 0, 0, 1, BYP));
    apply(mk(0, 1, 32'h704, 32'h0000_0704, 0, 1, 1, 1));
    push_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'h0);
    chk("arst_pop_valid", 64'(pop_valid), 64'h0);
    chk("arst_pop_instr", 64'(pop_instr), 64'(NOP));
    chk("arst_push_ready", 64'(push_ready), 64'h1);
    exp_q.delete();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Buffers fetched {pc, instr} pairs in a small circular FIFO with a valid/ready handshake on both sides.
- Presents the head entry to decode; decode consumes the 32-bit instr field.
- Absorbs decode stalls and discards all contents on a pipeline flush (branch/jump redirect).

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PC_W, 32, program counter width (equals `DBITS).
- INSTR_W, 32, instruction width (equals `INSTBITS).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all entries this cycle (redirect).
- push_valid  input  1  fetch offers an entry.
- push_ready  output  1  queue can accept an entry.
- push_pc  input  PC_W  PC of the offered instruction.
- push_instr  input  INSTR_W  offered instruction word.
- pop_valid  output  1  head entry valid for decode.
- pop_ready  input  1  decode consumes the head entry.
- pop_pc  output  PC_W  head entry PC.
- pop_instr  output  INSTR_W  head entry instruction, feeds decode instr.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, active-high): rd_ptr=0, wr_ptr=0, count=0.
  - Outputs during and after reset: pop_valid=0, push_ready=1, pop_pc=0, pop_instr=32'h00000013 (NOP).
  - Storage array is not reset.
- Asserting rst mid-operation discards all entries immediately, without waiting for a clock edge.
- Transfer rules:
  - push_fire = push_valid & push_ready.
  - pop_fire = pop_valid & pop_ready.
- push_ready = (count != DEPTH).
  - It is registered-state derived only; there is no combinational path from pop_ready.
  - When the queue is full, a simultaneous pop does not enable a push in that cycle.
- pop_valid = (count != 0).
  - pop_pc and pop_instr are read combinationally from mem[rd_ptr].
  - When empty, pop_pc=0 and pop_instr=NOP.
- On push_fire: mem[wr_ptr] <= {push_pc, push_instr}; wr_ptr advances by 1, wrapping at DEPTH.
- On pop_fire: rd_ptr advances by 1, wrapping at DEPTH.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal whenever 0 < count < DEPTH.
- Latency: an entry pushed in cycle N is visible at pop in cycle N+1 at the earliest (base configuration).
- Ordering: strict FIFO; no entry is duplicated or dropped except by flush.
- Flush (priority over push and pop):
  - Next cycle: rd_ptr=wr_ptr=0 and count=0.
  - A push presented in the flush cycle is dropped, and push_ready stays as computed from current state.
  - A pop in the flush cycle is ignored by the queue state.
- Input stability: fetch holds push_* stable while push_valid=1 and push_ready=0. The queue does not check this.
- Pointer width: $clog2(DEPTH). Occupancy is tracked by count, not by pointer comparison.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- When defined, an empty-queue bypass is added:
  - If count==0, push_valid=1 and no flush: pop_valid=1, pop_pc=push_pc, pop_instr=push_instr in the same cycle.
  - If pop_ready=1 in that cycle, the entry is not written and count stays 0. This gives zero-latency pass-through.
  - If pop_ready=0, the entry is written normally.
- When not defined: no bypass; minimum latency is 1 cycle and pop outputs depend only on registered state.

Test Plan:
- Reset behaviour: assert rst asynchronously mid-cycle with 2 entries held -> immediately count=0, pop_valid=0, pop_instr=32'h00000013, push_ready=1.
- Fill and drain with a stalled consumer:
  - Push pc 0x100..0x10C with instr 0x00500093, 0x00100113, 0x002081B3, 0x40208233 while pop_ready=0 -> count=4, push_ready=0.
  - A fifth push is held and not accepted.
  - Then pop_ready=1 -> entries pop in order over 4 cycles, count reaches 0.
- Simultaneous push and pop at count=2 for 10 cycles -> count stays 2, pointers wrap past DEPTH, pc sequence is continuous.
- Full plus pop: at count=4 with push_valid=1 and pop_ready=1 -> pop accepted, push not accepted, count=3 next cycle.
- Flush: at count=3 assert flush together with a push of pc 0x200 -> next cycle count=0, pop_valid=0, and 0x200 never appears at pop.
- Bypass (FETCHQ_BYPASS_EN defined): queue empty, push pc 0x300 instr 0x00000063 with pop_ready=1 -> pop_valid=1 with pop_pc=0x300 in the same cycle, count remains 0.
  - Without the macro the same stimulus gives pop_valid=1 one cycle later.
